// File: rtl/crc_bus_sequencer.sv
// Bus initiator for the CRC peripheral: programs POLY/CTRL/seed, streams N source words
// into DATA, then reads the CRC back. Optional result compare is enabled by CRC_CHECK_EN.
module crc_bus_sequencer #(
    parameter logic [31:0] BASE_ADDR = 32'h4003_2000,
    parameter logic [31:0] IDLE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      cfg_poly,
    input  logic [31:0]      cfg_ctrl,
    input  logic [31:0]      cfg_seed,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             src_valid,
    input  logic [31:0]      src_data,
    output logic             src_ready,
    output logic             Sel,
    output logic             RW,
    output logic [31:0]      addr,
    output logic [31:0]      data_wr,
    input  logic [31:0]      data_rd,
    output logic             busy,
    output logic             done,
    output logic [31:0]      result,
`ifdef CRC_CHECK_EN
    input  logic [31:0]      cfg_expect,
    output logic             match,
`endif
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        IDLE, W_POLY, W_CTRLS, W_SEED, W_CTRL, DATA, RD, DONE
    } state_t;

    localparam logic [31:0] WAS_BIT = 32'h0200_0000;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      poly_q, poly_d, ctrl_q, ctrl_d, seed_q, seed_d;
    logic             sel_q, sel_d, rw_q, rw_d, src_ready_q, src_ready_d;
    logic [31:0]      addr_q, addr_d, data_wr_q, data_wr_d, result_q, result_d;
    logic             busy_q, busy_d, done_q, done_d;
`ifdef CRC_CHECK_EN
    logic [31:0]      expect_q, expect_d;
    logic             match_q, match_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        poly_d      = poly_q;
        ctrl_d      = ctrl_q;
        seed_d      = seed_q;
        sel_d       = 1'b0;
        rw_d        = 1'b0;
        addr_d      = IDLE_ADDR;
        data_wr_d   = 32'h0;
        src_ready_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        result_d    = result_q;
`ifdef CRC_CHECK_EN
        expect_d    = expect_q;
        match_d     = match_q;
`endif
        // Outputs computed here describe the phase of the state being entered.
        case (state_q)
            IDLE: begin
                if (start) begin
                    poly_d    = cfg_poly;
                    ctrl_d    = cfg_ctrl;
                    seed_d    = cfg_seed;
                    cnt_d     = cfg_count;
`ifdef CRC_CHECK_EN
                    expect_d  = cfg_expect;
`endif
                    state_d   = W_POLY;
                    rw_d      = 1'b1;
                    addr_d    = BASE_ADDR + 32'd4;
                    data_wr_d = cfg_poly;
                    busy_d    = 1'b1;
                end
            end
            W_POLY: begin
                state_d   = W_CTRLS;
                rw_d      = 1'b1;
                addr_d    = BASE_ADDR + 32'd8;
                data_wr_d = ctrl_q | WAS_BIT;
            end
            W_CTRLS: begin
                state_d   = W_SEED;
                rw_d      = 1'b1;
                addr_d    = BASE_ADDR;
                data_wr_d = seed_q;
            end
            W_SEED: begin
                state_d     = W_CTRL;
                rw_d        = 1'b1;
                addr_d      = BASE_ADDR + 32'd8;
                data_wr_d   = ctrl_q & ~WAS_BIT;
                src_ready_d = (cnt_q != '0);
            end
            W_CTRL, DATA: begin
                // src_ready_q low here means every word has been accepted.
                if (src_ready_q && src_valid) begin
                    state_d     = DATA;
                    rw_d        = 1'b1;
                    addr_d      = BASE_ADDR;
                    data_wr_d   = src_data;
                    cnt_d       = cnt_q - CNT_W'(1);
                    src_ready_d = (cnt_q != CNT_W'(1));
                end else if (src_ready_q) begin
                    state_d     = DATA;
                    src_ready_d = 1'b1;
                end else begin
                    state_d = RD;
                    sel_d   = 1'b1;
                    addr_d  = BASE_ADDR;
                end
            end
            RD: begin
                state_d  = DONE;
                result_d = data_rd;
`ifdef CRC_CHECK_EN
                match_d  = (data_rd == expect_q);
`endif
                done_d   = 1'b1;
                busy_d   = 1'b0;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            poly_q      <= 32'h0;
            ctrl_q      <= 32'h0;
            seed_q      <= 32'h0;
            sel_q       <= 1'b0;
            rw_q        <= 1'b0;
            addr_q      <= IDLE_ADDR;
            data_wr_q   <= 32'h0;
            src_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= 32'h0;
`ifdef CRC_CHECK_EN
            expect_q    <= 32'h0;
            match_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            poly_q      <= poly_d;
            ctrl_q      <= ctrl_d;
            seed_q      <= seed_d;
            sel_q       <= sel_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            data_wr_q   <= data_wr_d;
            src_ready_q <= src_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
`ifdef CRC_CHECK_EN
            expect_q    <= expect_d;
            match_q     <= match_d;
`endif
        end
    end

    assign Sel       = sel_q;
    assign RW        = rw_q;
    assign addr      = addr_q;
    assign data_wr   = data_wr_q;
    assign src_ready = src_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign dbg_state = state_q;
`ifdef CRC_CHECK_EN
    assign match     = match_q;
`endif

endmodule

// File: tb/tb_crc_bus_sequencer.sv
// Directed bench for crc_bus_sequencer: bus writes are checked against an expected queue,
// with a stand-in slave returning a fixed value for the DATA read.
module tb_crc_bus_sequencer;
    localparam logic [31:0] BASE = 32'h4003_2000;
    localparam logic [31:0] IDLE = 32'h0000_0000;
    localparam logic [31:0] WAS  = 32'h0200_0000;

    // ---- clock / reset ----
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start = 1'b0;
    logic [31:0] cfg_poly = '0, cfg_ctrl = '0, cfg_seed = '0;
    logic [15:0] cfg_count = '0;
    logic        src_valid = 1'b0;
    logic [31:0] src_data = '0;
    logic        src_ready, Sel, RW, busy, done;
    logic [31:0] addr, data_wr, data_rd, result;
    logic [2:0]  dbg_state;
    logic [31:0] slave_rd = '0;
`ifdef CRC_CHECK_EN
    logic [31:0] cfg_expect = '0;
    logic        match;
`endif

    assign data_rd = (Sel && !RW && addr == BASE) ? slave_rd : 32'hDEAD_BEEF;

    crc_bus_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .cfg_poly(cfg_poly), .cfg_ctrl(cfg_ctrl),
        .cfg_seed(cfg_seed), .cfg_count(cfg_count), .src_valid(src_valid),
        .src_data(src_data), .src_ready(src_ready), .Sel(Sel), .RW(RW), .addr(addr),
        .data_wr(data_wr), .data_rd(data_rd), .busy(busy), .done(done), .result(result),
`ifdef CRC_CHECK_EN
        .cfg_expect(cfg_expect), .match(match),
`endif
        .dbg_state(dbg_state)
    );

    // ---- scoreboard ----
    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    bit mon_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Bus monitor: every write must be the next expected {addr,data}; non-writes idle or read.
    always @(negedge clk) begin
        if (mon_en) begin
            if (RW) begin
                chk("write_sel", {63'h0, Sel}, 64'h0);
                if (exp_q.size() == 0) chk("unexpected_write", {addr, data_wr}, 64'h0);
                else chk("bus_write", {addr, data_wr}, exp_q.pop_front());
            end else if (Sel) begin
                chk("read_addr", {32'h0, addr}, {32'h0, BASE});
            end else begin
                chk("idle_addr", {32'h0, addr}, {32'h0, IDLE});
            end
        end
    end

    // ---- driver ----
    task automatic run_seq(input logic [31:0] poly, ctrl, seed, input int n,
                           input bit zero_words, input int stall_at, stall_len,
                           input logic [31:0] rdv, input int exp_done, input bit glitch,
                           input logic [31:0] expv, input bit exp_match);
        logic [31:0] words[$];
        int sent = 0, stall_left = 0;
        bit got = 1'b0;
        slave_rd = rdv;
        for (int i = 0; i < n; i++) words.push_back(zero_words ? 32'h0 : $urandom);
        exp_q.push_back({BASE + 32'd4, poly});
        exp_q.push_back({BASE + 32'd8, ctrl | WAS});
        exp_q.push_back({BASE, seed});
        exp_q.push_back({BASE + 32'd8, ctrl & ~WAS});
        for (int i = 0; i < n; i++) exp_q.push_back({BASE, words[i]});
        cfg_poly = poly; cfg_ctrl = ctrl; cfg_seed = seed; cfg_count = 16'(n);
`ifdef CRC_CHECK_EN
        cfg_expect = expv;
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 80 && !got; k++) begin
            if (glitch && k == 2) begin
                start = 1'b1; cfg_poly = ~poly; cfg_seed = 32'h1; cfg_count = 16'd7;
`ifdef CRC_CHECK_EN
                cfg_expect = ~expv;
`endif
            end else start = 1'b0;
            src_valid = (sent < n) && (stall_left == 0);
            src_data  = src_valid ? words[sent] : $urandom;
            @(negedge clk);
            if (k == 1) chk("busy_start", {63'h0, busy}, 64'h1);
            if (done) begin
                got = 1'b1;
                chk("done_cycle", 64'(k), 64'(exp_done));
                chk("done_busy", {63'h0, busy}, 64'h0);
                chk("result", {32'h0, result}, {32'h0, rdv});
`ifdef CRC_CHECK_EN
                chk("match", {63'h0, match}, {63'h0, exp_match});
`endif
            end
            if (src_valid && src_ready) begin
                sent++;
                if (sent == stall_at) stall_left = stall_len;
            end else if (stall_left > 0) stall_left--;
            @(posedge clk); #1;
        end
        src_valid = 1'b0;
        if (!got) chk("done_timeout", 64'h0, 64'h1);
        @(negedge clk);
        chk("done_pulse", {62'h0, done, busy}, 64'h0);
        chk("queue_empty", 64'(exp_q.size()), 64'h0);
        exp_q.delete();
    endtask

    initial begin
        // reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1; mon_en = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {59'h0, Sel, RW, busy, done, src_ready}, 64'h0);
        chk("reset_addr_data", {addr, data_wr}, {IDLE, 32'h0});
        chk("reset_result", {32'h0, result}, 64'h0);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;

        // N=0: config writes only, result is the seed
        run_seq(32'h04C1_1DB7, 32'h0, 32'h0000_FFFF, 0, 1'b0, 0, 0, 32'h0000_FFFF, 6, 1'b0,
                32'h0000_FFFF, 1'b1);
        run_seq(32'h04C1_1DB7, 32'h0, 32'h0000_FFFF, 0, 1'b0, 0, 0, 32'h0000_FFFF, 6, 1'b0,
                32'h0000_1234, 1'b0);
        // N=1 zero word
        run_seq(32'h0000_1021, 32'h0, 32'h0, 1, 1'b1, 0, 0, 32'h0, 7, 1'b0, 32'h0, 1'b1);
        // N=4 with two idle phases after word 2; WAS bit in cfg must be overridden
        run_seq(32'h0000_8005, 32'hF300_0000, 32'hFFFF_FFFF, 4, 1'b0, 2, 2, 32'hA5A5_1234, 12,
                1'b0, 32'hA5A5_1234, 1'b1);
        // start pulsed while busy must be ignored
        run_seq(32'h1EDC_6F41, 32'h4100_0000, 32'h1234_5678, 2, 1'b0, 0, 0, 32'h0BAD_F00D, 8,
                1'b1, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        // longer random stream
        run_seq($urandom, $urandom & 32'hF100_0000, $urandom, 5, 1'b0, 0, 0, 32'h5555_AAAA, 11,
                1'b0, 32'h5555_AAAA, 1'b1);

        // reset mid-DATA: N=8, abort after 3 words
        exp_q.push_back({BASE + 32'd4, 32'h0000_1021});
        exp_q.push_back({BASE + 32'd8, WAS});
        exp_q.push_back({BASE, 32'h0});
        exp_q.push_back({BASE + 32'd8, 32'h0});
        cfg_poly = 32'h0000_1021; cfg_ctrl = 32'h0; cfg_seed = 32'h0; cfg_count = 16'd8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int sent = 0;
            for (int k = 0; k < 40 && sent < 3; k++) begin
                src_valid = 1'b1;
                src_data  = 32'h100 + 32'(sent);
                @(negedge clk);
                if (src_ready) begin
                    exp_q.push_back({BASE, src_data});
                    sent++;
                end
                @(posedge clk); #1;
            end
            if (sent < 3) chk("abort_fill_timeout", 64'(sent), 64'h3);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_bus", {30'h0, RW, busy, addr}, {32'h0, IDLE});
        chk("abort_ctl", {61'h0, Sel, src_ready, done}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        src_valid = 1'b0;
        chk("abort_queue", 64'(exp_q.size()), 64'h0);
        chk("abort_result", {32'h0, result}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
